// File: rtl/xpb_table_gen_if.sv
// Table-build request/status and table RAM write port; master = generator side.
interface xpb_table_gen_if #(
   parameter int WIDTH    = 1024,
   parameter int SEL_BITS = 5
);
   logic                start;
   logic [WIDTH-1:0]    modulus;
   logic [WIDTH-1:0]    base;
   logic                busy;
   logic                done;
   logic                err;
   logic                wr_valid;
   logic                wr_ready;
   logic [SEL_BITS-1:0] wr_addr;
   logic [WIDTH-1:0]    wr_data;

   modport master (
      input  start, modulus, base, wr_ready,
      output busy, done, err, wr_valid, wr_addr, wr_data
   );

   modport slave (
      output start, modulus, base, wr_ready,
      input  busy, done, err, wr_valid, wr_addr, wr_data
   );
endinterface

// File: rtl/xpb_table_gen.sv
// Writes (i*B) mod M for i = 0..2^SEL_BITS-1 into the table RAM; 2 cycles per entry plus stalls.
// Write port is valid/ready: a deasserted wr_ready holds wr_addr/wr_data stable until accepted.
module xpb_table_gen #(
   parameter int WIDTH    = 1024,
   parameter int SEL_BITS = 5
) (
   input  logic            clk,
   input  logic            rst,
   xpb_table_gen_if.master bus
);
   localparam logic [SEL_BITS-1:0] LAST_IDX = '1;

   typedef enum logic [1:0] {IDLE, EMIT, ADD} state_t;

   state_t              state_q, state_d;
   logic [WIDTH-1:0]    m_q, m_d;
   logic [WIDTH-1:0]    b_q, b_d;
   logic [WIDTH-1:0]    acc_q, acc_d;
   logic [SEL_BITS-1:0] idx_q, idx_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic                wr_valid_q, wr_valid_d;

   // acc < M and B < M, so acc+B < 2M: the carry bit matters only for the compare.
   logic [WIDTH:0]      sum;
   logic [WIDTH-1:0]    sum_red;
   logic                sum_ge_m;

   assign sum      = {1'b0, acc_q} + {1'b0, b_q};
   assign sum_red  = sum[WIDTH-1:0] - m_q;
   assign sum_ge_m = (sum >= {1'b0, m_q});

   always_comb begin
      state_d    = state_q;
      m_d        = m_q;
      b_d        = b_q;
      acc_d      = acc_q;
      idx_d      = idx_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      err_d      = err_q;
      wr_valid_d = wr_valid_q;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               m_d   = bus.modulus;
               b_d   = bus.base;
               idx_d = '0;
               acc_d = '0;
               if ((bus.modulus == '0) || (bus.base >= bus.modulus)) begin
                  done_d = 1'b1;
                  err_d  = 1'b1;
               end else begin
                  state_d    = EMIT;
                  busy_d     = 1'b1;
                  wr_valid_d = 1'b1;
               end
            end
         end
         EMIT: begin
            if (wr_valid_q && bus.wr_ready) begin
               wr_valid_d = 1'b0;
               if (idx_q == LAST_IDX) begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  err_d   = 1'b0;
               end else begin
                  state_d = ADD;
               end
            end
         end
         ADD: begin
            acc_d      = sum_ge_m ? sum_red : sum[WIDTH-1:0];
            idx_d      = idx_q + 1'b1;
            state_d    = EMIT;
            wr_valid_d = 1'b1;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         m_q        <= '0;
         b_q        <= '0;
         acc_q      <= '0;
         idx_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         wr_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         m_q        <= m_d;
         b_q        <= b_d;
         acc_q      <= acc_d;
         idx_q      <= idx_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
         wr_valid_q <= wr_valid_d;
      end
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.err      = err_q;
   assign bus.wr_valid = wr_valid_q;
   assign bus.wr_addr  = idx_q;
   assign bus.wr_data  = acc_q;
endmodule

// File: tb/tb_xpb_table_gen.sv
// Directed bench for xpb_table_gen: scoreboard of expected table writes plus timing/status checks.
module tb_xpb_table_gen;
   localparam int WIDTH    = 1024;
   localparam int SEL_BITS = 5;
   localparam int DEPTH    = 1 << SEL_BITS;

   typedef logic [WIDTH-1:0] word_t;
   typedef struct packed {
      logic [SEL_BITS-1:0] addr;
      word_t               data;
   } wr_t;

   logic  clk = 1'b0;
   logic  rst;
   int    n_tests = 0;
   int    n_fail  = 0;
   int    cyc     = 0;
   int    wcount  = 0;
   int    first_addr = -1;
   wr_t   exp_q[$];
   wr_t   mon_e;
   word_t cap [DEPTH];
   word_t all1;
   int    exp_basic [6];

   always #5 clk = ~clk;

   xpb_table_gen_if #(.WIDTH(WIDTH), .SEL_BITS(SEL_BITS)) bus ();

   xpb_table_gen #(.WIDTH(WIDTH), .SEL_BITS(SEL_BITS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chki(input string tag, input int obs, input int exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chkw(input string tag, input word_t obs, input word_t exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference table: straightforward modular multiply-accumulate with the % operator.
   task automatic push_model(input word_t m, input word_t b);
      logic [WIDTH:0] a;
      a = '0;
      for (int i = 0; i < DEPTH; i++) begin
         exp_q.push_back('{addr: i[SEL_BITS-1:0], data: a[WIDTH-1:0]});
         a = ({1'b0, a[WIDTH-1:0]} + {1'b0, b}) % {1'b0, m};
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic start_build(input word_t m, input word_t b);
      bus.modulus = m;
      bus.base    = b;
      bus.start   = 1'b1;
      cyc         = 0;
      tick();
      bus.start   = 1'b0;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (!bus.done && n < 300) begin
         tick();
         n++;
      end
      chk1("done_timeout", bus.done, 1'b1);
   endtask

   task automatic wait_addr(input int a);
      int n;
      n = 0;
      while (!(bus.wr_valid && (int'(bus.wr_addr) == a)) && n < 300) begin
         tick();
         n++;
      end
      chki("addr_timeout", int'(bus.wr_addr), a);
   endtask

   // Write monitor: sampled mid-cycle, a valid&ready here completes on the next rising edge.
   always @(negedge clk) begin
      if (!rst && bus.wr_valid && bus.wr_ready) begin
         chk1("sb_pending", exp_q.size() != 0, 1'b1);
         if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chki("wr_addr", int'(bus.wr_addr), int'(mon_e.addr));
            chkw("wr_data", bus.wr_data, mon_e.data);
         end
         cap[bus.wr_addr] = bus.wr_data;
         if (wcount == 0) first_addr = int'(bus.wr_addr);
         wcount++;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_basic = '{0, 40, 80, 23, 63, 6};
      all1 = '1;
      bus.start    = 1'b0;
      bus.modulus  = '0;
      bus.base     = '0;
      bus.wr_ready = 1'b1;
      rst = 1'b0;
      #2 rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk1("rst_busy", bus.busy, 1'b0);
      chk1("rst_done", bus.done, 1'b0);
      chk1("rst_err", bus.err, 1'b0);
      chk1("rst_wr_valid", bus.wr_valid, 1'b0);
      chki("rst_wr_addr", int'(bus.wr_addr), 0);
      chkw("rst_wr_data", bus.wr_data, '0);
      rst = 1'b0;
      tick();

      // Basic build
      wcount = 0;
      push_model(word_t'(97), word_t'(40));
      start_build(word_t'(97), word_t'(40));
      chk1("basic_busy", bus.busy, 1'b1);
      chk1("basic_first_valid", bus.wr_valid, 1'b1);
      wait_done();
      chki("basic_cycles", cyc, 64);
      chk1("basic_err", bus.err, 1'b0);
      chk1("basic_busy_end", bus.busy, 1'b0);
      chki("basic_writes", wcount, 32);
      chki("basic_sb_empty", exp_q.size(), 0);
      for (int i = 0; i < 6; i++) chkw("basic_entry", cap[i], word_t'(exp_basic[i]));
      chkw("basic_entry31", cap[31], word_t'(76));
      tick();
      chk1("basic_done_pulse", bus.done, 1'b0);

      // Backpressure on entry 5
      wcount = 0;
      push_model(word_t'(97), word_t'(40));
      start_build(word_t'(97), word_t'(40));
      wait_addr(5);
      bus.wr_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk1("bp_valid", bus.wr_valid, 1'b1);
         chki("bp_addr", int'(bus.wr_addr), 5);
         chkw("bp_data", bus.wr_data, word_t'(6));
      end
      bus.wr_ready = 1'b1;
      wait_done();
      chki("bp_cycles", cyc, 67);
      chki("bp_writes", wcount, 32);
      chki("bp_sb_empty", exp_q.size(), 0);
      tick();

      // Carry path: M = 2^W-1, B = M-1
      wcount = 0;
      push_model(all1, all1 - 1);
      start_build(all1, all1 - 1);
      wait_done();
      chkw("carry_entry1", cap[1], all1 - 1);
      chkw("carry_entry2", cap[2], all1 - 2);
      chkw("carry_entry31", cap[31], all1 - 31);
      chki("carry_writes", wcount, 32);
      tick();

      // Input rejection: B == M, then M == 0
      for (int t = 0; t < 2; t++) begin
         wcount = 0;
         if (t == 0) start_build(word_t'(97), word_t'(97));
         else        start_build('0, '0);
         chk1("rej_done", bus.done, 1'b1);
         chk1("rej_err", bus.err, 1'b1);
         chk1("rej_busy", bus.busy, 1'b0);
         chk1("rej_valid", bus.wr_valid, 1'b0);
         tick();
         chk1("rej_done_pulse", bus.done, 1'b0);
         chk1("rej_err_hold", bus.err, 1'b1);
         chk1("rej_valid2", bus.wr_valid, 1'b0);
         chki("rej_writes", wcount, 0);
      end
      wcount = 0;
      push_model(word_t'(97), word_t'(40));
      start_build(word_t'(97), word_t'(40));
      wait_done();
      chk1("err_cleared", bus.err, 1'b0);
      chki("recover_writes", wcount, 32);
      tick();

      // Reset while entry 10 is pending
      wcount = 0;
      push_model(word_t'(97), word_t'(40));
      start_build(word_t'(97), word_t'(40));
      wait_addr(10);
      rst = 1'b1;
      #1;
      chk1("midrst_valid", bus.wr_valid, 1'b0);
      chk1("midrst_busy", bus.busy, 1'b0);
      chk1("midrst_done", bus.done, 1'b0);
      exp_q.delete();
      tick();
      rst = 1'b0;
      tick();

      // Rebuild after reset, with start pulses ignored while busy
      wcount = 0;
      first_addr = -1;
      push_model(word_t'(101), word_t'(7));
      start_build(word_t'(101), word_t'(7));
      for (int k = 0; k < 3; k++) begin
         bus.modulus = word_t'(13);
         bus.base    = word_t'(5);
         bus.start   = 1'b1;
         tick();
         bus.start   = 1'b0;
         tick();
      end
      chk1("ignore_busy", bus.busy, 1'b1);
      wait_done();
      chki("rebuild_first_addr", first_addr, 0);
      chkw("rebuild_entry0", cap[0], '0);
      chki("rebuild_writes", wcount, 32);
      chki("rebuild_sb_empty", exp_q.size(), 0);

      // Start in the done cycle
      chk1("collide_done", bus.done, 1'b1);
      wcount = 0;
      push_model(word_t'(89), word_t'(17));
      start_build(word_t'(89), word_t'(17));
      chk1("collide_busy", bus.busy, 1'b1);
      wait_done();
      chki("collide_cycles", cyc, 64);
      chki("collide_writes", wcount, 32);
      chki("collide_sb_empty", exp_q.size(), 0);
      chk1("collide_err", bus.err, 1'b0);
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/xpb_table_gen.md
# xpb_table_gen

Runtime generator for the 32-entry precomputed-multiple tables used by the modular-squaring reduction stage. Given a modulus M and a base value B (B = 2^k mod M for the table's bit position), it produces entry i = (i·B) mod M for i = 0..31 in order. It drives a valid/ready write port into the table RAM that the reduction lookup later reads. The reader side stays a registered 5-bit-select, 1024-bit-output lookup; this block is the writer for it.

## Interface
- WIDTH, 1024, operand/entry width in bits
- SEL_BITS, 5, table index width; table depth = 2^SEL_BITS

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request a table build; sampled only when busy=0
- modulus  in  WIDTH  M; latched on accepted start
- base  in  WIDTH  B; latched on accepted start
- busy  out  1  build in progress
- done  out  1  one-cycle pulse at build end (success or error)
- err  out  1  valid with done: 1 = inputs rejected, no entries written
- wr_valid  out  1  write request valid
- wr_ready  in  1  table RAM accepts the write this cycle
- wr_addr  out  SEL_BITS  entry index
- wr_data  out  WIDTH  entry value

## Operation
- States: IDLE, EMIT, ADD.
- IDLE:
  - On start=1, latch M and B; idx=0, acc=0.
  - If M==0 or B>=M, stay IDLE and pulse done=1, err=1 next cycle. No write is issued.
  - Otherwise go to EMIT with busy=1.
- EMIT:
  - wr_valid=1, wr_addr=idx, wr_data=acc.
  - On wr_valid&&wr_ready: if idx==2^SEL_BITS−1, go to IDLE, busy=0, done=1 (err=0) for one cycle. Otherwise go to ADD.
  - With wr_ready=0, hold wr_addr and wr_data stable and stay in EMIT.
- ADD:
  - s = acc + B, computed at WIDTH+1 bits so the carry is kept.
  - acc <= (s >= M) ? s − M : s.
  - idx <= idx+1, then go to EMIT. wr_valid=0 in ADD.
- Invariant: acc < M at all times. Because B < M, one conditional subtract suffices.
- Entry 0 is always 0.
- start while busy=1 is ignored. Latched M and B do not change mid-build.
- start asserted in the same cycle done=1 is accepted, since the state is already IDLE.
- err holds its value until the next done pulse. It clears to 0 on a successful build's done.

## Timing
- Reset values: busy=0, done=0, err=0, wr_valid=0, wr_addr=0, wr_data=0. State=IDLE, acc=0, idx=0.
- All outputs are registered, except that async rst forces them to their reset values immediately.
- start accepted at edge E0 → wr_valid=1 for entry 0 in the cycle after E0.
- Entry i handshake at edge E(2i+1) with no backpressure. Each stall cycle adds one cycle.
- With wr_ready held at 1: 32 writes, last handshake at E63, done high during the cycle after E63. Build = 64 cycles from accept to done.
- Error path: done=err=1 in the cycle after E0. busy never rises.
- rst mid-build aborts immediately. No done pulse follows and the RAM contents are undefined. The next start rebuilds from entry 0.

## Test plan
- Basic build (M=97, B=40, wr_ready=1):
  - Writes addr 0..5 = 0, 40, 80, 23, 63, 6; addr 31 = 76; exactly 32 writes.
  - done one cycle, err=0, 64 cycles from accept to done.
- Backpressure (M=97, B=40, wr_ready=0 for 3 cycles while addr=5 is presented):
  - wr_addr=5 and wr_data=6 stay stable.
  - Build completes 67 cycles after accept; no duplicated or skipped addresses.
- Carry path (WIDTH=1024, M=2^1024−1, B=2^1024−2):
  - entry1 = 2^1024−2, entry2 = 2^1024−3, entry31 = 2^1024−1−31 = M−31.
- Input rejection:
  - M=97, B=97: done=err=1 one cycle after start, no wr_valid.
  - M=0, B=0: same response.
  - Then M=97, B=40 builds normally and err returns to 0.
- Reset and start collisions:
  - rst asserted while addr=10 is pending → wr_valid, busy and done read 0 immediately.
  - A new start after rst writes entry 0 = 0 first.
  - start pulses during busy are ignored.
  - start in the done cycle begins a second build immediately.
